// File: rtl/idma_axi_rd_arbiter_pkg.sv
// Shared constants for the iDMA AXI read arbiter: burst/response codes, FSM states, size helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package idma_axi_rd_arbiter_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // AR FSM: IDLE arbitrates, HOLD presents the registered command until accepted
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_HOLD = 1'b1;

    // ARSIZE encoding for a full-width beat of data_w bits
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/idma_axi_rd_arbiter_if.sv
// AXI4 read master port (AR + R channels) shared by the iDMA read requesters.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on both channels.
interface idma_axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 3
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [ID_W-1:0]   arid;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport master (
        output arvalid, araddr, arlen, arid, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  arvalid, araddr, arlen, arid, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/idma_axi_rd_arbiter_rr.sv
// Round-robin pick: first requesting index at or after ptr, wrapping; one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is taken.
module idma_axi_rd_arbiter_rr #(
    parameter  int N     = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             vld
);

    // Scan N positions starting at ptr; the first hit wins
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int off = 0; off < N; off++) begin
            int j;
            j = (int'(ptr) + off) % N;
            if (!vld && req[j]) begin
                vld    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/idma_axi_rd_arbiter.sv
// Shares one AXI4 read port among NUM_REQ requesters: RR grant into an AR slice, R demux by RID.
// Latency: AR 1 cycle from req_arvalid to m_axi.arvalid (one AR per 2 cycles); R path 0 cycles.
// Backpressure: AR held stable until arready; requester blocked at MAX_OUTST; R ready follows req_rready[rid].
module idma_axi_rd_arbiter
    import idma_axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 3,
    parameter int MAX_OUTST = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]      req_arlen,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [1:0]                req_rresp,
    output logic                      req_rlast,
    input  logic [NUM_REQ-1:0]        req_rready,
    idma_axi_rd_arbiter_if.master     m_axi,
    output logic                      busy,
    output logic                      err_sticky
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    logic [0:0]        state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  cnt_q [NUM_REQ];
    logic              err_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   win;
    logic               any_elig;
    logic               grant;
    logic [NUM_REQ-1:0] rid_hit;
    logic               r_hs;
    logic [NUM_REQ-1:0] cnt_dec;
    logic               cnt_nz;

    // A requester competes only while it still has outstanding-burst budget
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    idma_axi_rd_arbiter_rr #(.N(NUM_REQ)) u_rr (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win),
        .vld (any_elig)
    );

    // Grants are suppressed while reset is asserted so no arready leaks out
    assign grant       = !areset && (state_q == ARB_IDLE) && any_elig;
    assign req_arready = grant ? gnt : '0;

    assign m_axi.arvalid = (state_q == ARB_HOLD);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arid    = id_q;
    assign m_axi.arsize  = axi_size(DATA_W);
    assign m_axi.arburst = AXI_BURST_INCR;

    // AR FSM and register slice: capture winner's command, hold it until the fabric accepts
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        state_q <= ARB_HOLD;
                        addr_q  <= req_araddr[int'(win)*ADDR_W +: ADDR_W];
                        len_q   <= req_arlen[int'(win)*8 +: 8];
                        id_q    <= ID_W'(win);
                        ptr_q   <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    end
                end
                default: begin
                    if (m_axi.arready) begin
                        state_q <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // R demux: in-range RID steers valid/ready; unknown RIDs are drained with ready forced high
    always_comb begin
        req_rvalid   = '0;
        rid_hit      = '0;
        m_axi.rready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_axi.rid == ID_W'(i)) begin
                rid_hit[i]    = 1'b1;
                req_rvalid[i] = m_axi.rvalid;
                m_axi.rready  = req_rready[i];
            end
        end
    end

    assign req_rdata = m_axi.rdata;
    assign req_rresp = m_axi.rresp;
    assign req_rlast = m_axi.rlast;

    assign r_hs    = m_axi.rvalid && m_axi.rready;
    assign cnt_dec = {NUM_REQ{r_hs && m_axi.rlast}} & rid_hit;

    // Outstanding-burst counters and sticky protocol error
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_arready[i] && !cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (cnt_dec[i] && !req_arready[i]) begin
                    if (cnt_q[i] == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 1'b1;
                    end
                end
            end
            if (r_hs && (rid_hit == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Busy while a command sits in the slice or any burst is still owed data
    always_comb begin
        cnt_nz = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_nz = cnt_nz || (cnt_q[i] != '0);
        end
    end

    assign busy       = (state_q == ARB_HOLD) || cnt_nz;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_idma_axi_rd_arbiter.sv
// Self-checking bench for idma_axi_rd_arbiter with an AR scoreboard queue.
// Latency: n/a.
// Backpressure: bench drives arready/req_rready patterns directly.
module tb_idma_axi_rd_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int ID_W      = 3;
    localparam int MAX_OUTST = 2;

    logic                      aclk = 1'b0;
    logic                      areset;
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ-1:0]        req_arready;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [DATA_W-1:0]         req_rdata;
    logic [1:0]                req_rresp;
    logic                      req_rlast;
    logic [NUM_REQ-1:0]        req_rready;
    logic                      busy;
    logic                      err_sticky;

    idma_axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    idma_axi_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req_arvalid (req_arvalid),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arready (req_arready),
        .req_rvalid  (req_rvalid),
        .req_rdata   (req_rdata),
        .req_rresp   (req_rresp),
        .req_rlast   (req_rlast),
        .req_rready  (req_rready),
        .m_axi       (axi),
        .busy        (busy),
        .err_sticky  (err_sticky)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [7:0]      len;
    } ar_t;

    ar_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    function automatic logic [31:0] base_addr(input int i);
        return 32'h0000_0100 * 32'(i + 1);
    endfunction

    task automatic push_ar(input int id, input logic [31:0] addr, input logic [7:0] len);
        ar_t e;
        e.id   = ID_W'(id);
        e.addr = addr;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        req_arvalid = '0;
        req_rready  = '0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rid     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_araddr[i*ADDR_W +: ADDR_W] = base_addr(i);
            req_arlen[i*8 +: 8]            = 8'(i + 1);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        exp_q.delete();
    endtask

    // AR scoreboard: every accepted AR must match the oldest expected command
    always @(negedge aclk) begin
        if (!areset && axi.arvalid && axi.arready) begin
            ar_t e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL ar_unexpected: got arid=%0d addr=%h, required no AR", axi.arid, axi.araddr);
            end else begin
                e = exp_q.pop_front();
                if (axi.arid !== e.id || axi.araddr !== e.addr || axi.arlen !== e.len)
                    $display("FAIL ar_payload: got id=%0d addr=%h len=%0d, required id=%0d addr=%h len=%0d",
                             axi.arid, axi.araddr, axi.arlen, e.id, e.addr, e.len);
                else passes++;
            end
            checks++;
            if (axi.arsize !== 3'd3 || axi.arburst !== 2'b01)
                $display("FAIL ar_size_burst: got size=%0d burst=%0d, required 3/1", axi.arsize, axi.arburst);
            else passes++;
        end
    end

    task automatic test_reset();
        idle_inputs();
        areset      = 1'b1;
        req_arvalid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (req_arready !== 4'h0 || axi.arvalid !== 1'b0)
                $display("FAIL reset_ar: got arready=%b arvalid=%b, required 0000/0", req_arready, axi.arvalid);
            else passes++;
            checks++;
            if (busy !== 1'b0 || err_sticky !== 1'b0)
                $display("FAIL reset_status: got busy=%b err=%b, required 0/0", busy, err_sticky);
            else passes++;
        end
        areset      = 1'b0;
        req_arvalid = '0;
        step();
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_rdy;
        do_reset();
        axi.arready = 1'b1;
        req_arvalid = 4'hF;
        for (int k = 0; k < 8; k++) push_ar(k % 4, base_addr(k % 4), 8'((k % 4) + 1));
        for (int c = 0; c < 24; c++) begin
            #1;
            exp_rdy = (c < 16 && (c % 2) == 0) ? NUM_REQ'(1 << ((c / 2) % 4)) : '0;
            checks++;
            if (req_arready !== exp_rdy)
                $display("FAIL rr_arready c=%0d: got %b, required %b", c, req_arready, exp_rdy);
            else passes++;
            step();
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++;
            if (dut.cnt_q[i] !== 4'd2)
                $display("FAIL rr_cnt%0d: got %0d, required 2", i, dut.cnt_q[i]);
            else passes++;
        end
        checks++;
        if (busy !== 1'b1 || exp_q.size() != 0)
            $display("FAIL rr_end: got busy=%b pending=%0d, required 1/0", busy, exp_q.size());
        else passes++;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_araddr[2*ADDR_W +: ADDR_W] = 32'h0000_1000;
        req_arlen[2*8 +: 8]            = 8'd7;
        req_arvalid                    = 4'b0100;
        push_ar(2, 32'h0000_1000, 8'd7);
        #1;
        checks++;
        if (req_arready !== 4'b0100)
            $display("FAIL bp_grant: got %b, required 0100", req_arready);
        else passes++;
        step();
        req_arvalid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1000 || axi.arlen !== 8'd7 || axi.arid !== 3'd2)
                $display("FAIL bp_hold c=%0d: got v=%b addr=%h len=%0d id=%0d, required 1/1000/7/2",
                         c, axi.arvalid, axi.araddr, axi.arlen, axi.arid);
            else passes++;
            checks++;
            if (req_arready !== 4'b0000)
                $display("FAIL bp_no_pulse c=%0d: got %b, required 0000", c, req_arready);
            else passes++;
            step();
        end
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        #1;
        checks++;
        if (axi.arvalid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL bp_done: got arvalid=%b pending=%0d, required 0/0", axi.arvalid, exp_q.size());
        else passes++;
        idle_inputs();
    endtask

    task automatic test_r_routing();
        int          k;
        int          n;
        logic        tog;
        logic [63:0] exp_dat;
        do_reset();
        push_ar(1, base_addr(1), 8'd2);
        req_arvalid = 4'b0010;
        axi.arready = 1'b1;
        #1;
        checks++;
        if (req_arready !== 4'b0010)
            $display("FAIL r_setup_grant: got %b, required 0010", req_arready);
        else passes++;
        step();
        req_arvalid = '0;
        step();
        axi.arready = 1'b0;
        k   = 0;
        n   = 0;
        tog = 1'b0;
        while (k < 8 && n < 40) begin
            exp_dat    = 64'hA5A5_0000_0000_0000 | 64'(k);
            axi.rvalid = 1'b1;
            axi.rid    = 3'd1;
            axi.rdata  = exp_dat;
            axi.rlast  = (k == 7);
            req_rready = {2'b11, tog, 1'b1};
            #1;
            checks++;
            if (req_rvalid !== 4'b0010 || axi.rready !== tog)
                $display("FAIL r_route k=%0d: got rvalid=%b rready=%b, required 0010/%b", k, req_rvalid, axi.rready, tog);
            else passes++;
            checks++;
            if (req_rdata !== exp_dat || busy !== 1'b1)
                $display("FAIL r_data k=%0d: got data=%h busy=%b, required %h/1", k, req_rdata, busy, exp_dat);
            else passes++;
            step();
            if (tog) k++;
            tog = ~tog;
            n++;
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        req_rready = '0;
        #1;
        checks++;
        if (k != 8 || dut.cnt_q[1] !== 4'd0 || busy !== 1'b0 || err_sticky !== 1'b0)
            $display("FAIL r_done: got beats=%0d cnt1=%0d busy=%b err=%b, required 8/0/0/0",
                     k, dut.cnt_q[1], busy, err_sticky);
        else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        push_ar(3, base_addr(3), 8'd4);
        req_arvalid = 4'b1000;
        axi.arready = 1'b1;
        step();
        req_arvalid = '0;
        step();
        push_ar(3, base_addr(3), 8'd4);
        req_arvalid = 4'b1000;
        axi.rvalid  = 1'b1;
        axi.rid     = 3'd3;
        axi.rlast   = 1'b1;
        req_rready  = 4'b1000;
        #1;
        checks++;
        if (req_arready !== 4'b1000 || axi.rready !== 1'b1 || req_rvalid !== 4'b1000)
            $display("FAIL sim_both: got arready=%b rready=%b rvalid=%b, required 1000/1/1000",
                     req_arready, axi.rready, req_rvalid);
        else passes++;
        step();
        req_arvalid = '0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        req_rready  = '0;
        step();
        axi.arready = 1'b0;
        #1;
        checks++;
        if (dut.cnt_q[3] !== 4'd1 || err_sticky !== 1'b0 || exp_q.size() != 0)
            $display("FAIL sim_cnt: got cnt3=%0d err=%b pending=%0d, required 1/0/0",
                     dut.cnt_q[3], err_sticky, exp_q.size());
        else passes++;
        axi.rvalid = 1'b1;
        axi.rid    = 3'd6;
        axi.rlast  = 1'b1;
        #1;
        checks++;
        if (axi.rready !== 1'b1 || req_rvalid !== 4'b0000)
            $display("FAIL bad_rid_drain: got rready=%b rvalid=%b, required 1/0000", axi.rready, req_rvalid);
        else passes++;
        step();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        #1;
        checks++;
        if (err_sticky !== 1'b1 || dut.cnt_q[3] !== 4'd1)
            $display("FAIL bad_rid_err: got err=%b cnt3=%0d, required 1/1", err_sticky, dut.cnt_q[3]);
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        axi.arready = 1'b1;
        req_arvalid = 4'b0111;
        push_ar(0, base_addr(0), 8'd1);
        push_ar(1, base_addr(1), 8'd2);
        push_ar(2, base_addr(2), 8'd3);
        repeat (6) step();
        axi.arready = 1'b0;
        #1;
        checks++;
        if (req_arready !== 4'b0001)
            $display("FAIL mid_regrant: got %b, required 0001", req_arready);
        else passes++;
        step();
        req_arvalid = '0;
        #1;
        checks++;
        if (axi.arvalid !== 1'b1 || busy !== 1'b1 || exp_q.size() != 0)
            $display("FAIL mid_hold: got arvalid=%b busy=%b pending=%0d, required 1/1/0",
                     axi.arvalid, busy, exp_q.size());
        else passes++;
        areset = 1'b1;
        step();
        #1;
        checks++;
        if (axi.arvalid !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset: got arvalid=%b busy=%b, required 0/0", axi.arvalid, busy);
        else passes++;
        areset      = 1'b0;
        req_arvalid = 4'hF;
        #1;
        checks++;
        if (req_arready !== 4'b0001)
            $display("FAIL mid_ptr: got %b, required 0001", req_arready);
        else passes++;
        req_arvalid = '0;
        axi.rvalid  = 1'b1;
        axi.rid     = 3'd2;
        axi.rlast   = 1'b1;
        req_rready  = 4'b0100;
        step();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        req_rready = '0;
        #1;
        checks++;
        if (err_sticky !== 1'b1 || dut.cnt_q[2] !== 4'd0)
            $display("FAIL mid_stale_rlast: got err=%b cnt2=%0d, required 1/0", err_sticky, dut.cnt_q[2]);
        else passes++;
    endtask

    initial begin
        areset = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_r_routing();
        test_simultaneous();
        test_reset_mid();
        do_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passes, checks);
        $fatal(1);
    end

endmodule
